// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit side: scheduler state encoding,
// baud select codes and the default transmitter acceptance timeout.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ISSUE       = 2'd1,
        ST_WAIT_ACCEPT = 2'd2,
        ST_WAIT_DONE   = 2'd3
    } tx_state_e;

    localparam logic [1:0] BAUD_115200 = 2'd0;
    localparam logic [1:0] BAUD_9600   = 2'd1;
    localparam logic [1:0] BAUD_4800   = 2'd2;
    localparam logic [1:0] BAUD_2400   = 2'd3;

    localparam int ACK_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr_i,
// wrapping modulo NREQ, so the last winner gets lowest priority.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            any_o,
    output logic [IDW-1:0]  winner_o,
    output logic [NREQ-1:0] onehot_o
);

    int idx;

    // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        onehot_o = '0;
        idx      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (req_i[idx]) begin
                any_o    = 1'b1;
                winner_o = IDW'(idx);
            end
        end
        if (any_o) begin
            onehot_o[winner_o] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte producers;
// holds byte and baud for the whole frame and reports completion or timeout.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [2*NREQ-1:0] req_baud,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [1:0]        tx_baud_sel,
    input  logic              tx_ready,
    output logic              busy,
    output logic [IDW-1:0]    grant_id,
    output logic              done,
    output logic              timeout_err,
    output logic [IDW-1:0]    done_id
);

    localparam int              CNTW     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ACK_TIMEOUT - 1);
    localparam logic [IDW-1:0]  PTR_RST  = IDW'(NREQ - 1);

    tx_state_e       state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [1:0]      baud_q, baud_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic            busy_q, busy_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;
    logic [IDW-1:0]  done_id_q, done_id_d;

    logic            arb_any;
    logic [IDW-1:0]  arb_win;
    logic [NREQ-1:0] arb_onehot;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .any_o    (arb_any),
        .winner_o (arb_win),
        .onehot_o (arb_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= PTR_RST;
            cnt_q       <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            baud_q      <= '0;
            req_ready_q <= '0;
            busy_q      <= 1'b0;
            grant_q     <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            done_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            baud_q      <= baud_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            done_id_q   <= done_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        tx_start_d  = tx_start_q;
        tx_data_d   = tx_data_q;
        baud_d      = baud_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        grant_d     = grant_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        done_id_d   = done_id_q;

        case (state_q)
            ST_IDLE: begin
                if (en && tx_ready && arb_any) begin
                    tx_data_d   = req_data[8*int'(arb_win) +: 8];
                    baud_d      = req_baud[2*int'(arb_win) +: 2];
                    grant_d     = arb_win;
                    req_ready_d = arb_onehot;
                    tx_start_d  = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tx_start_d  = 1'b0;
                req_ready_d = '0;
                cnt_d       = '0;
                state_d     = ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT: begin
                if (!tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Transmitter never took the frame: drop it and move on.
                    timeout_d = 1'b1;
                    done_id_d = grant_q;
                    busy_d    = 1'b0;
                    rr_ptr_d  = grant_q;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_WAIT_DONE: begin
                // tx_data/tx_baud_sel stay put: the transmitter samples late in START.
                if (tx_ready) begin
                    done_d    = 1'b1;
                    done_id_d = grant_q;
                    busy_d    = 1'b0;
                    rr_ptr_d  = grant_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign tx_baud_sel = baud_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign done_id     = done_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: frame-level reference model checked every cycle,
// a simple transmitter/producer environment and directed scenarios with literal expectations.
module tb_uart_tx_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int ACKT = 16;
    localparam int FL   = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    always #10 clk = ~clk;

    int         pend [NREQ];
    logic [7:0] dat  [NREQ];
    logic [1:0] bd   [NREQ];

    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [2*NREQ-1:0] req_baud;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [1:0]        tx_baud_sel;
    logic              tx_ready = 1'b1;
    logic              busy;
    logic [IDW-1:0]    grant_id;
    logic              done;
    logic              timeout_err;
    logic [IDW-1:0]    done_id;

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_req
            assign req_valid[g]        = (pend[g] != 0);
            assign req_data[8*g +: 8]  = dat[g];
            assign req_baud[2*g +: 2]  = bd[g];
        end
    endgenerate

    uart_tx_sched #(.NREQ(NREQ), .IDW(IDW), .ACK_TIMEOUT(ACKT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_baud    (req_baud),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_baud_sel (tx_baud_sel),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .grant_id    (grant_id),
        .done        (done),
        .timeout_err (timeout_err),
        .done_id     (done_id)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Producers: one byte consumed per accept pulse.
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i] && pend[i] > 0) pend[i]--;
    end

    // Transmitter: drops ready after seeing start, stays busy FL cycles, or ignores start when stuck.
    bit stuck = 1'b0;
    int txc   = 0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ready = 1'b1;
            txc      = 0;
        end else if (stuck) begin
            tx_ready = 1'b1;
        end else if (txc > 0) begin
            txc--;
            if (txc == 0) tx_ready = 1'b1;
        end else if (tx_start) begin
            txc      = FL;
            tx_ready = 1'b0;
        end
    end

    // Reference model: tracks one frame by its age in cycles since the grant edge.
    bit              m_busy  = 0;
    bit              m_acc   = 0;
    int              m_age   = 0;
    int              m_last  = NREQ - 1;
    int              m_gid   = 0;
    int              m_did   = 0;
    bit              m_start = 0;
    bit              m_done  = 0;
    bit              m_to    = 0;
    logic [NREQ-1:0] m_rdy   = '0;
    logic [7:0]      m_data  = '0;
    logic [1:0]      m_baud  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_acc = 0; m_age = 0; m_last = NREQ - 1;
            m_gid = 0; m_did = 0; m_start = 0; m_done = 0; m_to = 0;
            m_rdy = '0; m_data = '0; m_baud = '0;
        end else begin
            m_done = 0;
            m_to   = 0;
            if (!m_busy) begin
                if (en && tx_ready && req_valid != '0) begin
                    int pick;
                    pick = -1;
                    for (int k = NREQ; k >= 1; k--)
                        if (req_valid[(m_last + k) % NREQ]) pick = (m_last + k) % NREQ;
                    m_busy  = 1; m_acc = 0; m_age = 0;
                    m_gid   = pick;
                    m_data  = dat[pick];
                    m_baud  = bd[pick];
                    m_rdy   = '0;
                    m_rdy[pick] = 1'b1;
                    m_start = 1;
                end
            end else begin
                m_age++;
                if (m_age == 1) begin
                    m_start = 0;
                    m_rdy   = '0;
                end else if (!m_acc) begin
                    if (!tx_ready) m_acc = 1;
                    else if (m_age == ACKT + 1) begin
                        m_to = 1; m_busy = 0; m_did = m_gid; m_last = m_gid;
                    end
                end else if (tx_ready) begin
                    m_done = 1; m_busy = 0; m_did = m_gid; m_last = m_gid;
                end
            end
        end
    end

    int q_gid[$];
    int q_dat[$];
    bit armed = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("tx_start",    int'(tx_start),    int'(m_start));
            chk("req_ready",   int'(req_ready),   int'(m_rdy));
            chk("busy",        int'(busy),        int'(m_busy));
            chk("grant_id",    int'(grant_id),    m_gid);
            chk("tx_data",     int'(tx_data),     int'(m_data));
            chk("tx_baud_sel", int'(tx_baud_sel), int'(m_baud));
            chk("done",        int'(done),        int'(m_done));
            chk("timeout_err", int'(timeout_err), int'(m_to));
            chk("done_id",     int'(done_id),     m_did);
            if (tx_start) begin
                chk("start_without_end", int'(armed), 0);
                armed = 1;
                q_gid.push_back(int'(grant_id));
                q_dat.push_back(int'(tx_data));
            end
            if (done || timeout_err) armed = 0;
        end else begin
            armed = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_start(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (tx_start) begin ok = 1; break; end
        end
        chk({nm, "_start_seen"}, int'(ok), 1);
    endtask

    task automatic wait_end(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done || timeout_err) begin ok = 1; break; end
        end
        chk({nm, "_end_seen"}, int'(ok), 1);
    endtask

    task automatic wait_in_frame(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy && !tx_ready && !tx_start) begin ok = 1; break; end
        end
        chk({nm, "_wait_done_seen"}, int'(ok), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        bit saw;
        int exp_g[5];
        int exp_d[5];
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; dat[i] = 8'h00; bd[i] = 2'd0;
        end
        tick();
        tick();
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_busy",     int'(busy), 0);
        chk("rst_req_rdy",  int'(req_ready), 0);
        chk("rst_grant",    int'(grant_id), 0);
        chk("rst_tx_data",  int'(tx_data), 0);
        chk("rst_done_id",  int'(done_id), 0);
        rst_n = 1'b1;

        // Single frame from requester 0.
        dat[0] = 8'h55; bd[0] = 2'd1; en = 1'b1;
        pend[0] = 1;
        wait_start("t1");
        chk("t1_tx_data",   int'(tx_data), 8'h55);
        chk("t1_baud",      int'(tx_baud_sel), 1);
        chk("t1_req_ready", int'(req_ready), 4'b0001);
        chk("t1_busy",      int'(busy), 1);
        wait_end("t1");
        chk("t1_done",    int'(done), 1);
        chk("t1_done_id", int'(done_id), 0);
        chk("t1_busy_end", int'(busy), 0);

        // All four pending: fair rotation from a fresh pointer.
        do_reset();
        q_gid.delete(); q_dat.delete();
        for (int i = 0; i < NREQ; i++) begin
            dat[i] = 8'hA0 + 8'(i); bd[i] = 2'(i);
        end
        pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
        for (int f = 0; f < 5; f++) begin
            wait_start("t2");
            wait_end("t2");
        end
        exp_g = '{0, 1, 2, 3, 0};
        exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        chk("t2_frames", q_gid.size(), 5);
        for (int f = 0; f < 5 && f < q_gid.size(); f++) begin
            chk("t2_grant_order", q_gid[f], exp_g[f]);
            chk("t2_data_order",  q_dat[f], exp_d[f]);
        end

        // Late arrivals during a frame from requester 2.
        dat[2] = 8'hC2;
        pend[2] = 1;
        wait_start("t3a");
        chk("t3_first_grant", int'(grant_id), 2);
        wait_in_frame("t3");
        pend[0] = 1; pend[3] = 1;
        wait_end("t3a");
        wait_start("t3b");
        chk("t3_second_grant", int'(grant_id), 3);
        wait_end("t3b");
        wait_start("t3c");
        chk("t3_third_grant", int'(grant_id), 0);
        wait_end("t3c");

        // Transmitter never drops ready.
        stuck = 1'b1;
        pend[1] = 1;
        wait_start("t4");
        cnt = 0; saw = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done) saw = 1;
            if (timeout_err) break;
            if (busy && !tx_start) cnt++;
        end
        chk("t4_timeout",      int'(timeout_err), 1);
        chk("t4_wait_cycles",  cnt, ACKT);
        chk("t4_done_id",      int'(done_id), 1);
        chk("t4_busy",         int'(busy), 0);
        chk("t4_no_done",      int'(saw), 0);
        stuck = 1'b0;
        tick();

        // Enable gating.
        en = 1'b0;
        pend[1] = 1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx_start) cnt++;
        end
        chk("t5_blocked_starts", cnt, 0);
        en = 1'b1;
        tick();
        chk("t5_start_after_en", int'(tx_start), 1);
        tick();
        en = 1'b0;
        wait_end("t5");
        chk("t5_done",    int'(done), 1);
        chk("t5_done_id", int'(done_id), 1);
        en = 1'b1;

        // Reset in the middle of a frame.
        pend[2] = 1;
        wait_start("t6");
        wait_in_frame("t6");
        rst_n = 1'b0;
        #1;
        chk("t6_async_busy",   int'(busy), 0);
        chk("t6_async_data",   int'(tx_data), 0);
        chk("t6_async_grant",  int'(grant_id), 0);
        chk("t6_async_done",   int'(done), 0);
        chk("t6_async_start",  int'(tx_start), 0);
        chk("t6_async_baud",   int'(tx_baud_sel), 0);
        tick();
        tick();
        rst_n = 1'b1;
        saw = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || timeout_err) saw = 1;
        end
        chk("t6_no_pulse", int'(saw), 0);
        pend[3] = 1;
        wait_start("t6b");
        chk("t6_grant",     int'(grant_id), 3);
        chk("t6_req_ready", int'(req_ready), 4'b1000);
        wait_end("t6b");
        chk("t6_done_id", int'(done_id), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
